dpram_arbiter: RTL and testbench
================================

# dpram_arbiter

Access controller placed in front of the 16x8 dual-port RAM: it serves two requester clients, one per RAM port. After reset it zero-fills the RAM, then forwards client accesses to the RAM ports. When both ports hit the same address and at least one access is a write, it resolves the conflict by round-robin, so the RAM never sees a same-address write collision. It also returns read data with a valid strobe and counts conflicts for debug.

## Interface
- DATA_W, 8, data width of the RAM and clients
- ADDR_W, 4, address width; RAM depth = 2^ADDR_W (must be even)
- CNT_W, 16, width of the saturating conflict counter
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_a / req_b  in  1  client request; must stay asserted with stable fields until granted
- we_a / we_b  in  1  1 = write, 0 = read
- addr_a / addr_b  in  ADDR_W  client address
- wdata_a / wdata_b  in  DATA_W  client write data
- gnt_a / gnt_b  out  1  access accepted this cycle (combinational)
- rvalid_a / rvalid_b  out  1  read data valid on rdata_x this cycle
- rdata_a / rdata_b  out  DATA_W  read data (ram_dout_x passed through)
- ram_addr_a / ram_addr_b  out  ADDR_W  to RAM address ports
- ram_din_a / ram_din_b  out  DATA_W  to RAM data-in ports
- ram_we_a / ram_we_b  out  1  to RAM write enables
- ram_dout_a / ram_dout_b  in  DATA_W  from RAM; registered, 1-cycle read latency
- init_done  out  1  high once the zero-fill sweep is complete
- collision  out  1  conflict being resolved this cycle (combinational)
- conflict_cnt  out  CNT_W  saturating count of resolved conflicts

## Operation
- FSM has two states, INIT and RUN; reset enters INIT.
- INIT: sweep index k runs 0..2^ADDR_W/2-1.
  - Each cycle, port A writes 0 to address 2k and port B writes 0 to address 2k+1.
  - gnt_x=0 throughout; client requests are ignored but not lost, since clients hold them.
  - After the last k, the FSM moves to RUN and init_done goes to 1 and stays there.
- RUN: conflict = req_a & req_b & (addr_a==addr_b) & (we_a|we_b).
  - Read/read to the same address is not a conflict; both are granted.
- No conflict: gnt_x = req_x.
- Conflict:
  - Only the port selected by the prio register (0=A, 1=B) is granted.
  - prio toggles on every conflict cycle.
  - collision=1 for that cycle.
  - conflict_cnt increments, saturating at 2^CNT_W-1.
  - The loser keeps requesting and is granted on a later cycle, at the latest the next cycle if the winner drops its request.
- RAM drive in RUN:
  - ram_addr_x = addr_x and ram_din_x = wdata_x.
  - ram_we_x = gnt_x & we_x. A loser never asserts we.
- rvalid_x is registered as gnt_x & ~we_x from the previous cycle; rdata_x = ram_dout_x.
- prio changes only on conflict cycles. Non-conflict cycles leave it unchanged.

## Timing
- Reset values (during and on the cycle after rst=1):
  - gnt_x=0, rvalid_x=0, ram_we_x=0, ram_addr_x=0, ram_din_x=0.
  - init_done=0, collision=0, conflict_cnt=0, prio=0 (A first), FSM in INIT with k=0.
- INIT starts on the first clock after rst deasserts.
- INIT lasts 2^(ADDR_W-1) cycles, i.e. 8 cycles at the defaults. init_done=1 from the following cycle.
- Grant is same-cycle (combinational). The RAM write occurs on the edge that ends the grant cycle.
- Read latency: grant in cycle N gives rvalid_x=1 with data in cycle N+1.
- A write granted in cycle N is visible to a read granted in cycle N+1 on either port.
- Simultaneous conflict plus saturated counter: the grant still alternates and the counter holds at max.
- Reset mid-operation:
  - Pending rvalid is cancelled (0 next cycle) and any in-flight INIT sweep restarts from k=0.
  - init_done, prio and conflict_cnt clear.
- Requests asserted during INIT are held off with gnt=0 and are granted in the first RUN cycle per the normal rules.

## Test plan
- Reset then idle:
  - ram_we_a/b=1 for 8 cycles, port A addresses 0,2..14 and port B addresses 1,3..15, data 0.
  - init_done rises on cycle 9.
  - A read of any address afterwards returns 0x00.
- Independent traffic after init:
  - A writes 0xAA@1 and B writes 0x55@2 in the same cycle; both are granted.
  - The next cycle A reads @1 and B reads @2.
  - One cycle later rvalid_a=1 with rdata_a=0xAA, and rvalid_b=1 with rdata_b=0x55.
- Write/write conflict:
  - A writes 0xF0@3 and B writes 0x0F@3, both held.
  - Cycle 1: gnt_a=1, gnt_b=0, collision=1. Cycle 2: gnt_b=1.
  - A later read of @3 returns 0x0F; conflict_cnt=1.
  - Repeating the scenario grants B first (prio toggled); conflict_cnt=2.
- Read/read to the same address @3: both are granted in the same cycle, collision=0, both return the same data.
- Read/write conflict with A reading @5 and B writing 0x77@5 while prio=A:
  - A is granted first and reads the old value 0x00.
  - B is granted the next cycle; a subsequent read returns 0x77.
- rst pulsed mid-sweep (cycle 4 of INIT), and again with rvalid pending:
  - rvalid drops and the sweep restarts at addresses 0/1.
  - conflict_cnt=0 and init_done=0 until the full 8-cycle sweep completes.
  - With CNT_W=2, five conflicts leave conflict_cnt=3.

Source files
------------

// File: rtl/dpram_arbiter_if.sv
// Client-side bus of the dual-port RAM access controller: one requester per
// RAM port (suffix _a and _b).
//
// Handshake: req_x acts as valid and gnt_x as ready. An access is transferred
// in a cycle where req_x && gnt_x. Once raised, req_x and its fields (we_x,
// addr_x, wdata_x) stay stable until that cycle. gnt_x is combinational.
// rvalid_x is a one-cycle strobe for a granted read and is never back-pressured.
interface dpram_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req_a;
  logic              we_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              gnt_a;
  logic              rvalid_a;
  logic [DATA_W-1:0] rdata_a;

  logic              req_b;
  logic              we_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              gnt_b;
  logic              rvalid_b;
  logic [DATA_W-1:0] rdata_b;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b
  );
endinterface

// File: rtl/dpram_arbiter.sv
// Access controller for a dual-port RAM with registered read data.
// After reset it zero-fills the RAM two words per cycle, then forwards client
// accesses, resolving same-address write hazards between the ports by
// round-robin and counting each resolved conflict (saturating).
module dpram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  dpram_arbiter_if.slave    bus,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic [DATA_W-1:0] ram_din_a,
  output logic [DATA_W-1:0] ram_din_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_dout_a,
  input  logic [DATA_W-1:0] ram_dout_b,
  output logic              init_done,
  output logic              collision,
  output logic [CNT_W-1:0]  conflict_cnt,
  output logic              dbg_state,
  output logic              dbg_prio,
  output logic [ADDR_W-2:0] dbg_k
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-2:0] K_LAST  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-2:0] k_q, k_d;
  // Low for the first cycle after reset so the sweep begins on the first
  // clock edge that sees rst released; that cycle shows pure reset values.
  logic              armed_q;
  logic              prio_q, prio_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rvalid_a_q, rvalid_b_q;
  logic              gnt_a, gnt_b;
  logic              conflict;

  assign conflict = bus.req_a & bus.req_b & (bus.addr_a == bus.addr_b)
                  & (bus.we_a | bus.we_b);

  // State, sweep index, priority, counter and read-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      k_q        <= '0;
      armed_q    <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      armed_q    <= 1'b1;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
      rvalid_a_q <= gnt_a & ~bus.we_a;
      rvalid_b_q <= gnt_b & ~bus.we_b;
    end
  end

  // Next state, grants and RAM drive; everything is held at zero during rst.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    collision  = 1'b0;
    ram_addr_a = '0;
    ram_addr_b = '0;
    ram_din_a  = '0;
    ram_din_b  = '0;
    ram_we_a   = 1'b0;
    ram_we_b   = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_INIT: begin
          if (armed_q) begin
            // Port A clears the even word, port B the odd word of pair k.
            ram_we_a   = 1'b1;
            ram_we_b   = 1'b1;
            ram_addr_a = {k_q, 1'b0};
            ram_addr_b = {k_q, 1'b1};
            if (k_q == K_LAST) begin
              state_d = ST_RUN;
              k_d     = '0;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          ram_addr_a = bus.addr_a;
          ram_addr_b = bus.addr_b;
          ram_din_a  = bus.wdata_a;
          ram_din_b  = bus.wdata_b;
          if (conflict) begin
            collision = 1'b1;
            gnt_a     = ~prio_q;
            gnt_b     = prio_q;
            prio_d    = ~prio_q;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          end else begin
            gnt_a = bus.req_a;
            gnt_b = bus.req_b;
          end
          ram_we_a = gnt_a & bus.we_a;
          ram_we_b = gnt_b & bus.we_b;
        end
        default: state_d = ST_INIT;
      endcase
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.rvalid_a = rvalid_a_q & ~rst;
  assign bus.rvalid_b = rvalid_b_q & ~rst;
  assign bus.rdata_a  = ram_dout_a;
  assign bus.rdata_b  = ram_dout_b;

  assign init_done    = ~rst & (state_q == ST_RUN);
  assign conflict_cnt = rst ? '0 : cnt_q;
  assign dbg_state    = state_q;
  assign dbg_prio     = prio_q;
  assign dbg_k        = k_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// Testbench for dpram_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural model of the arbitration rules and RAM.
module tb_dpram_arbiter;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int CNT_W   = 2;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dpram_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  logic [ADDR_W-1:0] ram_addr_a, ram_addr_b;
  logic [DATA_W-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;
  logic              ram_we_a, ram_we_b;
  logic              init_done, collision, dbg_state, dbg_prio;
  logic [CNT_W-1:0]  conflict_cnt;
  logic [ADDR_W-2:0] dbg_k;

  dpram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .ram_addr_a   (ram_addr_a),
    .ram_addr_b   (ram_addr_b),
    .ram_din_a    (ram_din_a),
    .ram_din_b    (ram_din_b),
    .ram_we_a     (ram_we_a),
    .ram_we_b     (ram_we_b),
    .ram_dout_a   (ram_dout_a),
    .ram_dout_b   (ram_dout_b),
    .init_done    (init_done),
    .collision    (collision),
    .conflict_cnt (conflict_cnt),
    .dbg_state    (dbg_state),
    .dbg_prio     (dbg_prio),
    .dbg_k        (dbg_k)
  );

  // Dual-port RAM with registered outputs; starts full of junk so the
  // zero-fill sweep is actually observed.
  logic [DATA_W-1:0] ram_mem [DEPTH];
  logic              scramble;
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DATA_W'($urandom);
    end else begin
      if (ram_we_a) ram_mem[ram_addr_a] <= ram_din_a;
      if (ram_we_b) ram_mem[ram_addr_b] <= ram_din_b;
    end
    ram_dout_a <= ram_mem[ram_addr_a];
    ram_dout_b <= ram_mem[ram_addr_b];
  end

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              ref_prio;
  int                ref_cnt;
  logic              m_gnt_a, m_gnt_b, m_coll;
  logic              m_rv_a, m_rv_b;
  logic [DATA_W-1:0] exp_q_a[$];
  logic [DATA_W-1:0] exp_q_b[$];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_prio = 1'b0;
    ref_cnt  = 0;
    m_rv_a   = 1'b0;
    m_rv_b   = 1'b0;
  endtask

  // Who should be granted in the current cycle, from the requests alone.
  task automatic model_eval();
    m_coll = bus.req_a && bus.req_b && (bus.addr_a == bus.addr_b) && (bus.we_a || bus.we_b);
    if (m_coll) begin
      m_gnt_a = !ref_prio;
      m_gnt_b = ref_prio;
    end else begin
      m_gnt_a = bus.req_a;
      m_gnt_b = bus.req_b;
    end
  endtask

  // Apply the granted accesses at the end of the cycle.
  task automatic model_commit();
    m_rv_a = m_gnt_a && !bus.we_a;
    m_rv_b = m_gnt_b && !bus.we_b;
    if (m_rv_a) exp_q_a.push_back(ref_mem[bus.addr_a]);
    if (m_rv_b) exp_q_b.push_back(ref_mem[bus.addr_b]);
    if (m_gnt_a && bus.we_a) ref_mem[bus.addr_a] = bus.wdata_a;
    if (m_gnt_b && bus.we_b) ref_mem[bus.addr_b] = bus.wdata_b;
    if (m_coll) begin
      ref_prio = !ref_prio;
      if (ref_cnt < CNT_MAX) ref_cnt++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_a(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data);
    bus.req_a = req; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = data;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data);
    bus.req_b = req; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = data;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
  endtask

  // Move to the sampling point of the current cycle.
  task automatic to_sample();
    @(negedge clk);
    model_eval();
  endtask

  // Close the current cycle and start the next one.
  task automatic to_next();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [ADDR_W-1:0] ra, rb;
    rst = 1'b1;
    set_a(1'b1, 1'b1, 4'd5, 8'h11);
    set_b(1'b1, 1'b1, 4'd5, 8'h22);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.gnt_a !== 1'b0) begin n_errors++; $display("FAIL rst_gnt_a: got %b want 0", bus.gnt_a); end
    n_checks++; if (bus.gnt_b !== 1'b0) begin n_errors++; $display("FAIL rst_gnt_b: got %b want 0", bus.gnt_b); end
    n_checks++; if ({ram_we_a, ram_we_b} !== 2'b00) begin n_errors++; $display("FAIL rst_ram_we: got %b want 00", {ram_we_a, ram_we_b}); end
    n_checks++; if ({ram_addr_a, ram_addr_b} !== '0) begin n_errors++; $display("FAIL rst_ram_addr: got %h/%h want 0/0", ram_addr_a, ram_addr_b); end
    n_checks++; if ({ram_din_a, ram_din_b} !== '0) begin n_errors++; $display("FAIL rst_ram_din: got %h/%h want 0/0", ram_din_a, ram_din_b); end
    n_checks++; if ({init_done, collision, bus.rvalid_a, bus.rvalid_b} !== 4'b0000) begin n_errors++; $display("FAIL rst_flags: got %b want 0000", {init_done, collision, bus.rvalid_a, bus.rvalid_b}); end
    n_checks++; if (conflict_cnt !== '0) begin n_errors++; $display("FAIL rst_cnt: got %0d want 0", conflict_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    n_checks++; if ({ram_we_a, ram_we_b, init_done} !== 3'b000) begin n_errors++; $display("FAIL post_rst_idle: got %b want 000", {ram_we_a, ram_we_b, init_done}); end
    for (int k = 0; k < DEPTH / 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if ({ram_we_a, ram_we_b} !== 2'b11) begin n_errors++; $display("FAIL init_we k=%0d: got %b want 11", k, {ram_we_a, ram_we_b}); end
      n_checks++; if (ram_addr_a !== ADDR_W'(2 * k) || ram_addr_b !== ADDR_W'(2 * k + 1)) begin n_errors++; $display("FAIL init_addr k=%0d: got %0d/%0d want %0d/%0d", k, ram_addr_a, ram_addr_b, 2 * k, 2 * k + 1); end
      n_checks++; if ({ram_din_a, ram_din_b} !== '0) begin n_errors++; $display("FAIL init_din k=%0d: got %h/%h want 0/0", k, ram_din_a, ram_din_b); end
      n_checks++; if (init_done !== 1'b0 || dbg_state !== 1'b0) begin n_errors++; $display("FAIL init_busy k=%0d: got done=%b state=%b want 0/0", k, init_done, dbg_state); end
      n_checks++; if (dbg_k !== (ADDR_W-1)'(k)) begin n_errors++; $display("FAIL init_k: got %0d want %0d", dbg_k, k); end
    end
    @(posedge clk); #1;
    model_reset();
    to_sample();
    n_checks++; if (init_done !== 1'b1 || dbg_state !== 1'b1) begin n_errors++; $display("FAIL init_done: got done=%b state=%b want 1/1", init_done, dbg_state); end
    n_checks++; if ({ram_we_a, ram_we_b} !== 2'b00) begin n_errors++; $display("FAIL idle_we: got %b want 00", {ram_we_a, ram_we_b}); end
    to_next();
    ra = ADDR_W'($urandom_range(0, DEPTH - 1));
    rb = ADDR_W'($urandom_range(0, DEPTH - 1));
    set_a(1'b1, 1'b0, ra, '0);
    set_b(1'b1, 1'b0, rb, '0);
    to_sample();
    n_checks++; if ({bus.gnt_a, bus.gnt_b} !== 2'b11) begin n_errors++; $display("FAIL zero_rd_gnt: got %b want 11", {bus.gnt_a, bus.gnt_b}); end
    to_next();
    idle();
    to_sample();
    n_checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h00) begin n_errors++; $display("FAIL zero_rd_a @%0d: got v=%b d=%h want 1/00", ra, bus.rvalid_a, bus.rdata_a); end
    n_checks++; if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'h00) begin n_errors++; $display("FAIL zero_rd_b @%0d: got v=%b d=%h want 1/00", rb, bus.rvalid_b, bus.rdata_b); end
    to_next();
  endtask

  task automatic test_independent();
    set_a(1'b1, 1'b1, 4'd1, 8'hAA);
    set_b(1'b1, 1'b1, 4'd2, 8'h55);
    to_sample();
    n_checks++; if ({bus.gnt_a, bus.gnt_b, collision} !== 3'b110) begin n_errors++; $display("FAIL ind_wr_gnt: got %b want 110", {bus.gnt_a, bus.gnt_b, collision}); end
    n_checks++; if ({ram_we_a, ram_we_b} !== 2'b11) begin n_errors++; $display("FAIL ind_wr_we: got %b want 11", {ram_we_a, ram_we_b}); end
    to_next();
    set_a(1'b1, 1'b0, 4'd1, '0);
    set_b(1'b1, 1'b0, 4'd2, '0);
    to_sample();
    n_checks++; if ({bus.gnt_a, bus.gnt_b} !== 2'b11) begin n_errors++; $display("FAIL ind_rd_gnt: got %b want 11", {bus.gnt_a, bus.gnt_b}); end
    to_next();
    idle();
    to_sample();
    n_checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'hAA) begin n_errors++; $display("FAIL ind_rd_a: got v=%b d=%h want 1/aa", bus.rvalid_a, bus.rdata_a); end
    n_checks++; if (bus.rvalid_b !== 1'b1 || bus.rdata_b !== 8'h55) begin n_errors++; $display("FAIL ind_rd_b: got v=%b d=%h want 1/55", bus.rvalid_b, bus.rdata_b); end
    to_next();
  endtask

  task automatic test_ww_conflict();
    set_a(1'b1, 1'b1, 4'd3, 8'hF0);
    set_b(1'b1, 1'b1, 4'd3, 8'h0F);
    to_sample();
    n_checks++; if ({bus.gnt_a, bus.gnt_b, collision} !== 3'b101) begin n_errors++; $display("FAIL ww1_c1: got gnt_a,gnt_b,coll=%b want 101", {bus.gnt_a, bus.gnt_b, collision}); end
    n_checks++; if (ram_we_b !== 1'b0) begin n_errors++; $display("FAIL ww1_loser_we: got %b want 0", ram_we_b); end
    to_next();
    set_a(1'b0, 1'b0, '0, '0);
    to_sample();
    n_checks++; if ({bus.gnt_b, collision} !== 2'b10) begin n_errors++; $display("FAIL ww1_c2: got gnt_b,coll=%b want 10", {bus.gnt_b, collision}); end
    to_next();
    set_a(1'b1, 1'b0, 4'd3, '0);
    set_b(1'b0, 1'b0, '0, '0);
    to_sample();
    to_next();
    idle();
    to_sample();
    n_checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h0F) begin n_errors++; $display("FAIL ww1_rd: got v=%b d=%h want 1/0f", bus.rvalid_a, bus.rdata_a); end
    n_checks++; if (conflict_cnt !== CNT_W'(1)) begin n_errors++; $display("FAIL ww1_cnt: got %0d want 1", conflict_cnt); end
    to_next();
    set_a(1'b1, 1'b1, 4'd3, 8'hF0);
    set_b(1'b1, 1'b1, 4'd3, 8'h0F);
    to_sample();
    n_checks++; if ({bus.gnt_a, bus.gnt_b, collision} !== 3'b011) begin n_errors++; $display("FAIL ww2_c1: got gnt_a,gnt_b,coll=%b want 011", {bus.gnt_a, bus.gnt_b, collision}); end
    to_next();
    set_b(1'b0, 1'b0, '0, '0);
    to_sample();
    n_checks++; if (bus.gnt_a !== 1'b1) begin n_errors++; $display("FAIL ww2_c2: got gnt_a=%b want 1", bus.gnt_a); end
    to_next();
    idle();
    to_sample();
    n_checks++; if (conflict_cnt !== CNT_W'(2)) begin n_errors++; $display("FAIL ww2_cnt: got %0d want 2", conflict_cnt); end
    to_next();
  endtask

  task automatic test_rr_same();
    set_a(1'b1, 1'b0, 4'd3, '0);
    set_b(1'b1, 1'b0, 4'd3, '0);
    to_sample();
    n_checks++; if ({bus.gnt_a, bus.gnt_b, collision} !== 3'b110) begin n_errors++; $display("FAIL rr_gnt: got %b want 110", {bus.gnt_a, bus.gnt_b, collision}); end
    to_next();
    idle();
    to_sample();
    n_checks++; if ({bus.rvalid_a, bus.rvalid_b} !== 2'b11 || bus.rdata_a !== 8'hF0 || bus.rdata_b !== 8'hF0) begin n_errors++; $display("FAIL rr_data: got v=%b %h/%h want 11 f0/f0", {bus.rvalid_a, bus.rvalid_b}, bus.rdata_a, bus.rdata_b); end
    to_next();
  endtask

  task automatic test_rw_conflict();
    set_a(1'b1, 1'b0, 4'd5, '0);
    set_b(1'b1, 1'b1, 4'd5, 8'h77);
    to_sample();
    n_checks++; if ({bus.gnt_a, bus.gnt_b, collision, ram_we_b} !== 4'b1010) begin n_errors++; $display("FAIL rw_c1: got gnt_a,gnt_b,coll,we_b=%b want 1010", {bus.gnt_a, bus.gnt_b, collision, ram_we_b}); end
    to_next();
    set_a(1'b0, 1'b0, '0, '0);
    to_sample();
    n_checks++; if ({bus.gnt_b, ram_we_b} !== 2'b11) begin n_errors++; $display("FAIL rw_c2: got gnt_b,we_b=%b want 11", {bus.gnt_b, ram_we_b}); end
    n_checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h00) begin n_errors++; $display("FAIL rw_old: got v=%b d=%h want 1/00", bus.rvalid_a, bus.rdata_a); end
    to_next();
    set_a(1'b1, 1'b0, 4'd5, '0);
    set_b(1'b0, 1'b0, '0, '0);
    to_sample();
    to_next();
    idle();
    to_sample();
    n_checks++; if (bus.rvalid_a !== 1'b1 || bus.rdata_a !== 8'h77) begin n_errors++; $display("FAIL rw_new: got v=%b d=%h want 1/77", bus.rvalid_a, bus.rdata_a); end
    n_checks++; if (conflict_cnt !== CNT_W'(3)) begin n_errors++; $display("FAIL rw_cnt: got %0d want 3", conflict_cnt); end
    to_next();
  endtask

  task automatic test_reset_mid();
    // Reset with a read response pending.
    set_a(1'b1, 1'b0, 4'd0, '0);
    to_sample();
    to_next();
    rst = 1'b1;
    idle();
    @(negedge clk);
    n_checks++; if (bus.rvalid_a !== 1'b0) begin n_errors++; $display("FAIL mid_rv_in_rst: got %b want 0", bus.rvalid_a); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({bus.rvalid_a, init_done} !== 2'b00 || conflict_cnt !== '0) begin n_errors++; $display("FAIL mid_cleared: got rv,done=%b cnt=%0d want 00 0", {bus.rvalid_a, init_done}, conflict_cnt); end
    // Reset again in the fourth sweep cycle.
    repeat (3) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if ({ram_we_a, ram_we_b} !== 2'b00) begin n_errors++; $display("FAIL mid_sweep_rst_we: got %b want 00", {ram_we_a, ram_we_b}); end
    @(posedge clk); #1;
    rst = 1'b0;
    set_a(1'b1, 1'b0, 4'd4, '0);
    set_b(1'b1, 1'b0, 4'd4, '0);
    @(negedge clk);
    for (int k = 0; k < DEPTH / 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++; if (ram_addr_a !== ADDR_W'(2 * k) || ram_addr_b !== ADDR_W'(2 * k + 1) || {ram_we_a, ram_we_b} !== 2'b11) begin n_errors++; $display("FAIL resweep k=%0d: got %0d/%0d we=%b want %0d/%0d 11", k, ram_addr_a, ram_addr_b, {ram_we_a, ram_we_b}, 2 * k, 2 * k + 1); end
      n_checks++; if ({bus.gnt_a, bus.gnt_b, init_done} !== 3'b000 || conflict_cnt !== '0) begin n_errors++; $display("FAIL resweep_hold k=%0d: got gnt,done=%b cnt=%0d want 000 0", k, {bus.gnt_a, bus.gnt_b, init_done}, conflict_cnt); end
    end
    @(posedge clk); #1;
    model_reset();
    to_sample();
    n_checks++; if ({init_done, bus.gnt_a, bus.gnt_b, collision} !== 4'b1110) begin n_errors++; $display("FAIL first_run: got done,gnt_a,gnt_b,coll=%b want 1110", {init_done, bus.gnt_a, bus.gnt_b, collision}); end
    to_next();
    // Back-to-back conflicts: grants alternate A,B,... and the counter saturates.
    for (int i = 0; i < 5; i++) begin
      logic exp_ga;
      int   exp_cnt;
      exp_ga  = (i % 2 == 0);
      exp_cnt = (i < CNT_MAX) ? i : CNT_MAX;
      set_a(1'b1, 1'b1, 4'd7, 8'hA5);
      set_b(1'b1, 1'b1, 4'd7, 8'h5B);
      to_sample();
      n_checks++; if ({bus.gnt_a, bus.gnt_b, collision} !== {exp_ga, !exp_ga, 1'b1}) begin n_errors++; $display("FAIL sat_gnt i=%0d: got %b want %b", i, {bus.gnt_a, bus.gnt_b, collision}, {exp_ga, !exp_ga, 1'b1}); end
      n_checks++; if (conflict_cnt !== exp_cnt[CNT_W-1:0]) begin n_errors++; $display("FAIL sat_cnt i=%0d: got %0d want %0d", i, conflict_cnt, exp_cnt); end
      to_next();
    end
    idle();
    to_sample();
    n_checks++; if (conflict_cnt !== CNT_W'(CNT_MAX) || collision !== 1'b0) begin n_errors++; $display("FAIL sat_final: got cnt=%0d coll=%b want %0d 0", conflict_cnt, collision, CNT_MAX); end
    to_next();
  endtask

  task automatic test_random();
    logic              pa, pb, wa, wb;
    logic [ADDR_W-1:0] aa, ab;
    logic [DATA_W-1:0] da, db, exp_d;
    pa = 1'b0; pb = 1'b0; wa = 1'b0; wb = 1'b0;
    aa = '0; ab = '0; da = '0; db = '0;
    exp_q_a.delete();
    exp_q_b.delete();
    for (int c = 0; c < 400; c++) begin
      if (!pa && $urandom_range(0, 9) < 7) begin
        pa = 1'b1; wa = 1'($urandom_range(0, 1));
        aa = ADDR_W'($urandom_range(0, 3)); da = DATA_W'($urandom);
      end
      if (!pb && $urandom_range(0, 9) < 7) begin
        pb = 1'b1; wb = 1'($urandom_range(0, 1));
        ab = ADDR_W'($urandom_range(0, 3)); db = DATA_W'($urandom);
      end
      set_a(pa, wa, aa, da);
      set_b(pb, wb, ab, db);
      to_sample();
      n_checks++; if ({bus.gnt_a, bus.gnt_b} !== {m_gnt_a, m_gnt_b}) begin n_errors++; $display("FAIL rnd_gnt c=%0d: got %b want %b", c, {bus.gnt_a, bus.gnt_b}, {m_gnt_a, m_gnt_b}); end
      n_checks++; if (collision !== m_coll || dbg_prio !== ref_prio) begin n_errors++; $display("FAIL rnd_coll c=%0d: got coll=%b prio=%b want %b %b", c, collision, dbg_prio, m_coll, ref_prio); end
      n_checks++; if (conflict_cnt !== ref_cnt[CNT_W-1:0]) begin n_errors++; $display("FAIL rnd_cnt c=%0d: got %0d want %0d", c, conflict_cnt, ref_cnt); end
      n_checks++; if ({ram_we_a, ram_we_b} !== {m_gnt_a & wa, m_gnt_b & wb}) begin n_errors++; $display("FAIL rnd_we c=%0d: got %b want %b", c, {ram_we_a, ram_we_b}, {m_gnt_a & wa, m_gnt_b & wb}); end
      n_checks++; if (ram_addr_a !== aa || ram_addr_b !== ab || ram_din_a !== da || ram_din_b !== db) begin n_errors++; $display("FAIL rnd_drive c=%0d: got %0d/%0d %h/%h want %0d/%0d %h/%h", c, ram_addr_a, ram_addr_b, ram_din_a, ram_din_b, aa, ab, da, db); end
      n_checks++; if ({bus.rvalid_a, bus.rvalid_b} !== {m_rv_a, m_rv_b}) begin n_errors++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, {bus.rvalid_a, bus.rvalid_b}, {m_rv_a, m_rv_b}); end
      if (m_rv_a) begin
        exp_d = exp_q_a.pop_front();
        n_checks++; if (bus.rdata_a !== exp_d) begin n_errors++; $display("FAIL rnd_rdata_a c=%0d: got %h want %h", c, bus.rdata_a, exp_d); end
      end
      if (m_rv_b) begin
        exp_d = exp_q_b.pop_front();
        n_checks++; if (bus.rdata_b !== exp_d) begin n_errors++; $display("FAIL rnd_rdata_b c=%0d: got %h want %h", c, bus.rdata_b, exp_d); end
      end
      if (m_gnt_a) pa = 1'b0;
      if (m_gnt_b) pb = 1'b0;
      to_next();
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst      = 1'b1;
    scramble = 1'b1;
    idle();
    @(posedge clk); #1;
    scramble = 1'b0;
    test_reset();
    test_independent();
    test_ww_conflict();
    test_rr_same();
    test_rw_conflict();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
